mem_access_arbiter: RTL
=======================

// Module: mem_access_arbiter
// PURPOSE
//  Sequences every access to the single-port unified memory of the multi-cycle CPU.
//  Shares that memory between instruction fetch (IF) and load/store (LS) requesters
//    with round-robin priority.
//  Holds a fixed-latency access for LAT cycles, then captures read data into its
//    internal memory-data register.
//  Returns a one-cycle done pulse to the winning requester.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width
//  LAT     2   memory access latency in cycles; legal range 1..15
// PORTS
//  CLK        in   1       clock, rising edge
//  Reset      in   1       synchronous reset, active-high
//  if_req     in   1       IF request valid
//  if_addr    in   ADDR_W  IF read address
//  if_gnt     out  1       IF request accepted this cycle
//  if_done    out  1       IF access complete; rd_data valid
//  ls_req     in   1       LS request valid
//  ls_we      in   1       LS write (1) / read (0)
//  ls_addr    in   ADDR_W  LS address
//  ls_wdata   in   DATA_W  LS store data
//  ls_gnt     out  1       LS request accepted this cycle
//  ls_done    out  1       LS access complete
//  rd_data    out  DATA_W  memory-data register (last read result)
//  mem_en     out  1       memory enable
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data; valid in last ACCESS cycle
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset values
//   - State IDLE.
//   - All outputs 0: rd_data, mem_*, done, gnt, busy.
//   - last_ls = 0, so LS wins the first tie.
//  FSM
//   - IDLE -> ACCESS on any request.
//   - ACCESS: counter cnt loaded with LAT-1, decremented each cycle.
//     ACCESS -> DONE when cnt == 0.
//   - DONE -> IDLE unconditionally.
//  Handshake
//   - Accept: req && gnt. Accepted only in IDLE.
//   - gnt is combinational and only one gnt is high per cycle.
//   - Requester holds req and its operands until gnt, then may drop them.
//   - Requests that arrive while not in IDLE wait; nothing is queued.
//  Arbitration
//   - A single requester is always granted.
//   - When both request, grant the one not granted last (last_ls flag).
//   - last_ls updates on every accept.
//  Operand capture
//   - On accept, capture addr, we and wdata. Force we = 0 for IF.
//   - In ACCESS: mem_en = 1 and mem_addr/mem_we/mem_wdata are driven from the
//     captured values, stable for all LAT cycles.
//   - Outside ACCESS: mem_en = mem_we = 0; mem_addr and mem_wdata hold their values.
//  Completion
//   - On the final ACCESS cycle of a read: rd_data <= mem_rdata.
//   - rd_data is unchanged by writes and holds until the next read completes.
//   - In DONE, exactly one of if_done/ls_done is 1, for one cycle.
//  Timing
//   - Accept at cycle t gives mem_en for t+1..t+LAT and done at t+LAT+1.
//   - Next accept possible at t+LAT+2.
//  Reset mid-operation
//   - The access is aborted and the next state is IDLE.
//   - No done pulse; rd_data is cleared to 0.
// TESTING
//  1. Hold Reset 2 cycles -> all outputs 0, busy = 0. No gnt for a request held
//     during reset.
//  2. LAT=2, if_req, if_addr=0x00400000 at c0 -> if_gnt c0; mem_en=1 and
//     mem_addr=0x00400000 c1-c2; mem_rdata=0x8C220004 at c2 -> rd_data=0x8C220004
//     and if_done=1 at c3.
//  3. ls_req, we=1, addr=0x10010004, wdata=0xDEADBEEF -> mem_we=1 for 2 cycles
//     with that addr/data; ls_done at c3; rd_data unchanged.
//  4. if_req and ls_req both held after reset -> ls_gnt c0, ls_done c3, if_gnt c4,
//     if_done c7; both again -> LS granted (alternation).
//  5. Reset asserted at c1 of an LS read -> IDLE at c2; no ls_done; rd_data = 0;
//     mem_en = 0.
//  6. LAT=1, IF read requests issued back to back -> gnt every 3 cycles; mem_en
//     exactly 1 cycle each; rd_data tracks each mem_rdata.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter that shares the single-port unified memory between
// instruction fetch and load/store, running fixed-latency accesses.
module mem_access_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_ls;
  logic             cur_ls;
  logic             idle;

  // Grants are combinational; on a tie the requester not served last wins.
  assign idle   = (state == S_IDLE) && !Reset;
  assign if_gnt = idle && if_req && (!ls_req || last_ls);
  assign ls_gnt = idle && ls_req && (!if_req || !last_ls);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_ls   <= 1'b0;
      cur_ls    <= 1'b0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      rd_data   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_gnt || ls_gnt) begin
            state   <= S_ACCESS;
            cnt     <= CNT_W'(LAT - 1);
            last_ls <= ls_gnt;
            cur_ls  <= ls_gnt;
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            // Memory-side registers double as the captured operands.
            if (ls_gnt) begin
              mem_addr  <= ls_addr;
              mem_we    <= ls_we;
              mem_wdata <= ls_wdata;
            end else begin
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
            end
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            state   <= S_DONE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              rd_data <= mem_rdata;
            end
            if_done <= !cur_ls;
            ls_done <= cur_ls;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
